// File: rtl/tnn_neuron_accum.sv
// Ternary-neuron back end: accumulates (pc_pos - pc_neg) over N_CHUNKS beats
// and thresholds the signed total into a trit delivered over valid/ready.
module tnn_neuron_accum #(
    parameter int PC_W     = 5,
    parameter int N_CHUNKS = 4,
    parameter int ACC_W    = 8,
    parameter int TH_POS   = 4,
    parameter int TH_NEG   = -4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  pc_pos,
    input  logic [PC_W-1:0]  pc_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_trit,
    output logic [ACC_W-1:0] out_sum,
    output logic             dbg_state
);

    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_CHUNKS - 1);
    localparam logic signed [ACC_W-1:0] TH_POS_C = TH_POS[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] TH_NEG_C = TH_NEG[ACC_W-1:0];

    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_ZERO = 2'b00;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_d;
    logic [1:0]              trit_d;
    logic [ACC_W-1:0]        sum_d;

    logic signed [ACC_W:0]   term;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] next_sum;
    logic [1:0]              next_trit;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. in_ready is high only in ACCUM and out of reset; once
    // out_valid rises, out_trit/out_sum hold until out_ready is seen high
    // (or clr / reset discards the result).
    assign in_ready  = rst_n && (state_q == S_ACCUM);
    assign dbg_state = state_q;

    assign term = $signed({{(ACC_W + 1 - PC_W){1'b0}}, pc_pos})
                - $signed({{(ACC_W + 1 - PC_W){1'b0}}, pc_neg});
    assign sum_wide = $signed({acc_q[ACC_W-1], acc_q}) + term;
    assign next_sum = sum_wide[ACC_W-1:0];

    always_comb begin
        next_trit = TRIT_ZERO;
        if (next_sum >= TH_POS_C) begin
            next_trit = TRIT_POS;
        end else if (next_sum <= TH_NEG_C) begin
            next_trit = TRIT_NEG;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = out_valid;
        trit_d  = out_trit;
        sum_d   = out_sum;
        if (clr) begin
            // Abort: drop any partial sum or pending result.
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = S_ACCUM;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_CNT) begin
                            sum_d   = next_sum;
                            trit_d  = next_trit;
                            valid_d = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            acc_d = next_sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = S_ACCUM;
                    end
                end
                default: begin
                    state_d = S_ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_trit  <= TRIT_ZERO;
            out_sum   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_valid <= valid_d;
            out_trit  <= trit_d;
            out_sum   <= sum_d;
        end
    end

endmodule
